// File: rtl/kanagawa_hal_ram_pkg.sv
// Shared types and helpers for the multi-read HAL RAM.
package kanagawa_hal_ram_pkg;

  typedef enum logic [1:0] {
    ST_INIT  = 2'd0,
    ST_CLEAR = 2'd1,
    ST_READY = 2'd2
  } ram_state_e;

  localparam int MAX_READ_LATENCY = 4;
  localparam int MAX_DATA_WIDTH   = 256;
  localparam int MAX_IDX_W        = 8;

  // Callers zero-extend to MAX_DATA_WIDTH and truncate the result back.
  function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
    input logic [MAX_DATA_WIDTH-1:0] old_word,
    input logic [MAX_DATA_WIDTH-1:0] new_word,
    input logic [MAX_DATA_WIDTH-1:0] be,
    input int                        byte_width
  );
    logic [MAX_DATA_WIDTH-1:0] merged;
    for (int i = 0; i < MAX_DATA_WIDTH; i++) begin
      merged[MAX_IDX_W'(i)] = be[MAX_IDX_W'(i / byte_width)] ? new_word[MAX_IDX_W'(i)]
                                                              : old_word[MAX_IDX_W'(i)];
    end
    return merged;
  endfunction

endpackage

// File: rtl/kanagawa_hal_ram_read_pipe.sv
// Per-port read pipeline: captures the sampled word, then delays it to the
// configured latency. Data holds while no request is in flight.
module kanagawa_hal_ram_read_pipe #(
  parameter int DATA_WIDTH   = 32,
  parameter int READ_LATENCY = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  s1_valid_in,
  input  logic [DATA_WIDTH-1:0] s1_data_in,
  output logic                  rd_valid_out,
  output logic [DATA_WIDTH-1:0] rd_data_out
);

  logic [READ_LATENCY-1:0]                 valid_q, valid_d;
  logic [READ_LATENCY-1:0][DATA_WIDTH-1:0] data_q, data_d;

  always_comb begin
    valid_d    = '0;
    data_d     = data_q;
    valid_d[0] = s1_valid_in;
    if (s1_valid_in) data_d[0] = s1_data_in;
    for (int i = 1; i < READ_LATENCY; i++) begin
      valid_d[i] = valid_q[i-1];
      if (valid_q[i-1]) data_d[i] = data_q[i-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign rd_valid_out = valid_q[READ_LATENCY-1];
  assign rd_data_out  = data_q[READ_LATENCY-1];

endmodule

// File: rtl/kanagawa_hal_multi_read_ram.sv
// HAL RAM: one byte-masked write port, NUM_RD_PORTS pipelined read ports,
// optional post-reset clear. KANAGAWA_HAL_RAM_WRITE_BYPASS_EN forwards same-cycle writes to reads.
module kanagawa_hal_multi_read_ram
  import kanagawa_hal_ram_pkg::*;
#(
  parameter int                    DATA_WIDTH        = 32,
  parameter int                    BYTE_WIDTH        = 8,
  parameter int                    ADDR_WIDTH        = 6,
  parameter int                    DEPTH             = 2**ADDR_WIDTH,
  parameter int                    NUM_RD_PORTS      = 2,
  parameter int                    READ_LATENCY      = 1,
  parameter int                    CLEAR_ON_RESET    = 1,
  parameter logic [DATA_WIDTH-1:0] CLEAR_VALUE       = '0,
  parameter string                 INITIAL_DATA_FILE = "UNUSED"
) (
  input  logic                                     clk,
  input  logic                                     rst_n,
  input  logic                                     wr_en_in,
  input  logic [ADDR_WIDTH-1:0]                    wr_addr_in,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]         wr_be_in,
  input  logic [DATA_WIDTH-1:0]                    wr_data_in,
  input  logic [NUM_RD_PORTS-1:0]                  rd_en_in,
  input  logic [NUM_RD_PORTS-1:0][ADDR_WIDTH-1:0]  rd_addr_in,
  output logic [NUM_RD_PORTS-1:0][DATA_WIDTH-1:0]  rd_data_out,
  output logic [NUM_RD_PORTS-1:0]                  rd_valid_out,
  output logic                                     ready_out
);

  localparam logic [ADDR_WIDTH:0]   DEPTH_LIM = (ADDR_WIDTH+1)'(DEPTH);
  localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);

  if (CLEAR_ON_RESET != 0 && INITIAL_DATA_FILE != "UNUSED") begin : g_chk_init
    $error("CLEAR_ON_RESET would overwrite INITIAL_DATA_FILE");
  end
  if (DATA_WIDTH % BYTE_WIDTH != 0) begin : g_chk_bw
    $error("DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end
  if (READ_LATENCY < 1 || READ_LATENCY > MAX_READ_LATENCY) begin : g_chk_lat
    $error("READ_LATENCY must be 1..4");
  end
  if (DATA_WIDTH > MAX_DATA_WIDTH) begin : g_chk_dw
    $error("DATA_WIDTH exceeds byte_merge capacity");
  end

  // Sized to the full address space so indexing never truncates; only DEPTH words are used.
  logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

  ram_state_e            state_q, state_d;
  logic [ADDR_WIDTH-1:0] clr_addr_q, clr_addr_d;
  logic                  ready;
  logic                  wr_fire;
  logic [DATA_WIDTH-1:0] wr_merged;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;

  assign ready     = (state_q == ST_READY);
  assign ready_out = ready;

  always_comb begin
    state_d    = state_q;
    clr_addr_d = clr_addr_q;
    case (state_q)
      ST_INIT: begin
        clr_addr_d = '0;
        state_d    = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_READY;
      end
      ST_CLEAR: begin
        clr_addr_d = clr_addr_q + ADDR_WIDTH'(1);
        if (clr_addr_q == LAST_ADDR) state_d = ST_READY;
      end
      default: state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_INIT;
      clr_addr_q <= '0;
    end else begin
      state_q    <= state_d;
      clr_addr_q <= clr_addr_d;
    end
  end

  assign wr_fire   = ready && wr_en_in && ({1'b0, wr_addr_in} < DEPTH_LIM);
  assign wr_merged = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(mem[wr_addr_in]),
                                            MAX_DATA_WIDTH'(wr_data_in),
                                            MAX_DATA_WIDTH'(wr_be_in), BYTE_WIDTH));

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = wr_addr_in;
    mem_wdata = wr_merged;
    if (state_q == ST_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = clr_addr_q;
      mem_wdata = CLEAR_VALUE;
    end else if (wr_fire) begin
      mem_we = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  end

  for (genvar p = 0; p < NUM_RD_PORTS; p++) begin : g_rd
    logic                  s1_valid;
    logic [DATA_WIDTH-1:0] s1_word;

    always_comb begin
      s1_valid = ready && rd_en_in[p];
      s1_word  = '0;
      if ({1'b0, rd_addr_in[p]} < DEPTH_LIM) begin
        s1_word = mem[rd_addr_in[p]];
`ifdef KANAGAWA_HAL_RAM_WRITE_BYPASS_EN
        if (wr_fire && (wr_addr_in == rd_addr_in[p])) s1_word = wr_merged;
`endif
      end
    end

    kanagawa_hal_ram_read_pipe #(
      .DATA_WIDTH   (DATA_WIDTH),
      .READ_LATENCY (READ_LATENCY)
    ) u_pipe (
      .clk          (clk),
      .rst_n        (rst_n),
      .s1_valid_in  (s1_valid),
      .s1_data_in   (s1_word),
      .rd_valid_out (rd_valid_out[p]),
      .rd_data_out  (rd_data_out[p])
    );
  end

endmodule
